// File: rtl/arm_pkg.sv
// Shared definitions for the ARM fetch pipeline: word width, bubble word
// and the instruction-fetch FSM encoding.
package arm_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] NOP_WORD = '0;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } if_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: async active-low reset to RESET_VAL,
// synchronous load of the next-PC value when load_en is high.
module pc_reg
    import arm_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [WORD_W-1:0] pc_d,
    output logic [WORD_W-1:0] pc_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_VAL;
        end else if (load_en) begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address
// and captures the fetched word into the IF/ID register.
//
//   state | meaning
//   BOOT  | first cycle after reset: load a bubble, PC unchanged
//   RUN   | normal fetch, PC advances by PC_STEP per captured word
//   HALT  | fetch stopped at HALT_ADDR; PC held, bubbles every cycle
module if_stage
    import arm_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [WORD_W-1:0] HALT_ADDR = 32'h0000_0400,
    parameter logic [WORD_W-1:0] PC_STEP   = 32'd4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_addr,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_inst,
    output logic [WORD_W-1:0] if_pc,
    output logic [WORD_W-1:0] if_inst,
    output logic              if_valid,
    output logic              halted
);

    if_state_e         state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d, pc_inc, branch_tgt;
    logic              pc_load;
    logic [WORD_W-1:0] if_pc_q, if_pc_d;
    logic [WORD_W-1:0] if_inst_q, if_inst_d;
    logic              if_valid_q, if_valid_d;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^branch_addr[1:0];
    assign branch_tgt      = {branch_addr[WORD_W-1:2], 2'b00};
    assign pc_inc          = pc_q + PC_STEP;

    pc_reg #(
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_en (pc_load),
        .pc_d    (pc_d),
        .pc_q    (pc_q)
    );

    always_comb begin
        state_d    = state_q;
        pc_load    = 1'b0;
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if_valid_d = if_valid_q;

        // Branch flushes the wrong-path word and beats freeze and BOOT alike.
        if (branch_taken) begin
            pc_load    = 1'b1;
            pc_d       = branch_tgt;
            if_pc_d    = '0;
            if_inst_d  = NOP_WORD;
            if_valid_d = 1'b0;
            state_d    = RUN;
        end else if (state_q == BOOT) begin
            if_pc_d    = '0;
            if_inst_d  = NOP_WORD;
            if_valid_d = 1'b0;
            state_d    = RUN;
        end else if (freeze) begin
            state_d = state_q;
        end else if (state_q == HALT || pc_q == HALT_ADDR) begin
            if_pc_d    = '0;
            if_inst_d  = NOP_WORD;
            if_valid_d = 1'b0;
            state_d    = HALT;
        end else begin
            pc_load    = 1'b1;
            pc_d       = pc_inc;
            if_pc_d    = pc_inc;
            if_inst_d  = imem_inst;
            if_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            if_pc_q    <= '0;
            if_inst_q  <= NOP_WORD;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
        end
    end

    assign imem_addr = pc_q;
    assign if_pc     = if_pc_q;
    assign if_inst   = if_inst_q;
    assign if_valid  = if_valid_q;
    assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_if_stage.sv
// Randomized scoreboard bench for if_stage: a behavioural fetch model queues the
// expected post-edge outputs, and a monitor compares them against the DUT.
module tb_if_stage;

    localparam logic [31:0] HALT_A = 32'h0000_0400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        freeze = 1'b0, branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic [31:0] imem_addr, imem_inst, if_pc, if_inst;
    logic        if_valid, halted;

    logic [31:0] w_imem_addr, w_imem_inst, w_if_pc, w_if_inst;
    logic        w_if_valid, w_halted;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ {a[31:16], 16'h0};
    endfunction

    assign imem_inst   = mem(imem_addr);
    assign w_imem_inst = mem(w_imem_addr);

    if_stage dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .imem_addr(imem_addr), .imem_inst(imem_inst),
        .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid), .halted(halted)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n), .freeze(1'b0), .branch_taken(1'b0),
        .branch_addr(32'h0), .imem_addr(w_imem_addr), .imem_inst(w_imem_inst),
        .if_pc(w_if_pc), .if_inst(w_if_inst), .if_valid(w_if_valid), .halted(w_halted)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
        logic        halt;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: fetch pointer, lifecycle phase and the IF/ID contents.
    logic [31:0] m_pc, m_ifpc, m_inst;
    logic        m_valid;
    bit          m_booting, m_halted;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ifpc = '0; m_inst = '0; m_valid = 1'b0;
        m_booting = 1'b1; m_halted = 1'b0;
    endtask

    task automatic bubble();
        m_valid = 1'b0; m_inst = '0;
    endtask

    // One clock of stimulus, starting and ending at a falling edge.
    task automatic step(input logic fr, input logic br, input logic [31:0] ba);
        exp_t e;
        freeze = fr; branch_taken = br; branch_addr = ba;
        if (br) begin
            m_pc = ba & 32'hFFFF_FFFC;
            bubble();
            m_booting = 1'b0; m_halted = 1'b0;
        end else if (m_booting) begin
            bubble();
            m_booting = 1'b0;
        end else if (fr) begin
        end else if (m_halted || m_pc == HALT_A) begin
            bubble();
            m_halted = 1'b1;
        end else begin
            m_inst  = mem(m_pc);
            m_ifpc  = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
        end
        e.addr = m_pc; e.pc = m_ifpc; e.inst = m_inst; e.valid = m_valid; e.halt = m_halted;
        exp_q.push_back(e);
        @(negedge clk);
        freeze = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_addr"},  imem_addr, 32'h0);
        chk({tag, "_valid"}, {31'h0, if_valid}, 32'h0);
        chk({tag, "_inst"},  if_inst, 32'h0);
        chk({tag, "_pc"},    if_pc, 32'h0);
        chk({tag, "_halt"},  {31'h0, halted}, 32'h0);
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, releases at a falling edge.
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs(tag);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_until(input logic [31:0] target);
        for (int k = 0; k < 2000 && m_pc != target; k++) step(1'b0, 1'b0, 32'h0);
        chk("reach_pc", m_pc, target);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("imem_addr", imem_addr, e.addr);
                chk("if_valid", {31'h0, if_valid}, {31'h0, e.valid});
                chk("if_inst", if_inst, e.inst);
                chk("halted", {31'h0, halted}, {31'h0, e.halt});
                if (e.valid) chk("if_pc", if_pc, e.pc);
            end
        end
    end

    initial begin : timeout
        #1_000_000;
        $display("FAIL timeout: bench did not finish within 1000000 time units");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic fr, br;
        logic [31:0] ba;
        model_reset();
        @(negedge clk);
        check_reset_outputs("por");
        chk("wrap_reset_addr", w_imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch after reset, plus the wrap instance after one fetch.
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("wrap_addr", w_imem_addr, 32'h0);
        chk("wrap_if_pc", w_if_pc, 32'h0);
        chk("wrap_valid", {31'h0, w_if_valid}, 32'h1);
        chk("wrap_inst", w_if_inst, mem(32'hFFFF_FFFC));
        run_until(32'h8);

        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("resume_if_pc", if_pc, 32'd12);

        run_until(32'h10);
        step(1'b0, 1'b1, 32'h0000_0103);
        step(1'b0, 1'b0, 32'h0);
        chk("branch_if_pc", if_pc, 32'h104);

        step(1'b1, 1'b1, 32'h0000_0202);
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);

        step(1'b0, 1'b1, 32'h0000_03F0);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 32'h0);
        chk("halt_addr", imem_addr, HALT_A);
        chk("halt_flag", {31'h0, halted}, 32'h1);
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("restart_halted", {31'h0, halted}, 32'h0);

        run_until(32'h20);
        do_reset("midrun");
        step(1'b1, 1'b1, 32'h0000_0044);
        step(1'b0, 1'b0, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            fr = ($urandom % 5) == 0;
            br = ($urandom % 20) == 0;
            if (($urandom % 3) == 0) ba = 32'h3C0 + $urandom_range(0, 32'h4F);
            else ba = $urandom_range(0, 32'h3FF);
            if (($urandom % 600) == 0) do_reset("rand_rst");
            else step(fr, br, ba);
        end

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
